// File: rtl/midi_pkg.sv
// Shared constants, message layout and length decode for the MIDI message parser.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] PITCH    = 4'hE;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] TUNE_REQ    = 8'hF6;
    localparam logic [7:0] RT_FIRST    = 8'hF8;
    localparam logic [7:0] RT_UNDEF    = 8'hFD;

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

    typedef struct packed {
        logic [7:0] status;
        logic [6:0] d1;
        logic [6:0] d2;
        logic [1:0] len;
    } msg_t;

    function automatic logic is_system(input logic [7:0] status);
        return status[7:4] == 4'hF;
    endfunction

    // Number of data bytes that follow a status byte; 0 for anything that carries none.
    function automatic logic [1:0] data_len(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd0;
        case (status[7:4])
            NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: len = 2'd2;
            PROG, CH_AT:                           len = 2'd1;
            4'hF: begin
                if (status == 8'hF1 || status == 8'hF3) len = 2'd1;
                else if (status == 8'hF2)               len = 2'd2;
            end
            default: len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// Show-ahead valid/ready FIFO; a push into a full FIFO is accepted only alongside a pop.
module midi_msg_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_accepted,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             pop;

    assign out_valid     = count != '0;
    assign full          = count == CW'(DEPTH);
    assign pop           = out_valid & out_ready;
    assign push_accepted = push & (~full | pop);
    assign out_data      = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_accepted) wr_ptr <= wr_ptr + AW'(1);
            if (pop)           rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_accepted) - CW'(pop);
        end
    end

    // NOTE: storage is deliberately left unreset; out_data is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push_accepted) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/midi_msg_parser.sv
// Assembles MIDI bytes into status/data messages with running status, real-time
// interleave, SysEx discard and channel filtering, queued in a show-ahead FIFO.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int          FIFO_DEPTH        = 4,
    parameter logic [15:0] CHANNEL_MASK      = 16'hFFFF,
    parameter int          RUNNING_STATUS_EN = 1,
    parameter int          NOTE_OFF_CONVERT  = 1
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_strobe,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       overflow
);
    state_t     state;
    logic [7:0] cur_status;
    logic [6:0] d1;
    logic [1:0] cur_len;
    logic       completes;
    logic       push_req;
    logic       push_accepted;
    logic       fifo_full;
    msg_t       push_msg;
    msg_t       head;

    assign cur_len = data_len(cur_status);

    // Push decision is combinational so the entry lands on the same edge as the final byte.
    always_comb begin
        push_req  = 1'b0;
        push_msg  = '0;
        completes = 1'b0;
        if (byte_strobe) begin
            if (byte_in >= RT_FIRST) begin
                push_req        = byte_in != RT_UNDEF;
                push_msg.status = byte_in;
            end else if (byte_in == TUNE_REQ) begin
                push_req        = 1'b1;
                push_msg.status = byte_in;
            end else if (!byte_in[7]) begin
                if (state == WAIT_D1 && cur_len == 2'd1) begin
                    completes   = 1'b1;
                    push_msg.d1 = byte_in[6:0];
                end else if (state == WAIT_D2) begin
                    completes   = 1'b1;
                    push_msg.d1 = d1;
                    push_msg.d2 = byte_in[6:0];
                end
            end
        end
        if (completes) begin
            push_msg.status = cur_status;
            push_msg.len    = cur_len;
            if (NOTE_OFF_CONVERT != 0 && cur_status[7:4] == NOTE_ON && push_msg.d2 == 7'd0)
                push_msg.status = {NOTE_OFF, cur_status[3:0]};
            push_req = is_system(cur_status) || CHANNEL_MASK[cur_status[3:0]];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_status <= '0;
            d1         <= '0;
        end else if (byte_strobe && byte_in < RT_FIRST) begin
            if (byte_in[7]) begin
                d1 <= '0;
                if (byte_in == SYSEX_START) begin
                    state      <= SYSEX;
                    cur_status <= '0;
                end else if (data_len(byte_in) == 2'd0) begin
                    state      <= IDLE;
                    cur_status <= '0;
                end else begin
                    state      <= WAIT_D1;
                    cur_status <= byte_in;
                end
            end else if (completes) begin
                if (RUNNING_STATUS_EN != 0 && !is_system(cur_status)) begin
                    state <= WAIT_D1;
                end else begin
                    state      <= IDLE;
                    cur_status <= '0;
                end
            end else if (state == WAIT_D1) begin
                d1    <= byte_in[6:0];
                state <= WAIT_D2;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst)                              overflow <= 1'b0;
        else if (push_req && !push_accepted && fifo_full) overflow <= 1'b1;
    end

    midi_msg_fifo #(
        .WIDTH ($bits(msg_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (sys_clk),
        .rst           (rst),
        .push          (push_req),
        .push_data     (push_msg),
        .push_accepted (push_accepted),
        .out_valid     (msg_valid),
        .out_ready     (msg_ready),
        .out_data      (head),
        .full          (fifo_full)
    );

    assign msg_status = head.status;
    assign msg_data1  = head.d1;
    assign msg_data2  = head.d2;
    assign msg_len    = head.len;

endmodule
